// File: rtl/attack_ctl.sv
// Per-player attack sequencer: fire edge -> timed attack window -> cooldown -> re-arm.
// Define ATTACK_AUTOREPEAT_EN to relaunch on a held fire level instead of a fire edge.
module attack_ctl #(
  parameter int          ATTACK_FRAMES   = 12,
  parameter int          COOLDOWN_FRAMES = 20,
  parameter int          OFFS_X          = 40,
  parameter int          OFFS_Y          = 10,
  parameter int          H_LIMIT         = 800,
  parameter int          V_LIMIT         = 600,
  parameter logic [11:0] PARK            = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic [1:0]  fire,
  input  logic [1:0]  dir_in,
  input  logic [11:0] p0_x,
  input  logic [11:0] p0_y,
  input  logic [11:0] p1_x,
  input  logic [11:0] p1_y,
  output logic [23:0] x_pos,
  output logic [23:0] y_pos,
  output logic        direction,
  output logic [1:0]  active,
  output logic [1:0]  busy
);

  typedef enum logic [1:0] {IDLE, ATTACK, COOLDOWN} state_t;

  localparam logic [12:0] X_MAX  = 13'(H_LIMIT - 1);
  localparam logic [12:0] Y_MAX  = 13'(V_LIMIT - 1);
  localparam logic [12:0] OX     = 13'(OFFS_X);
  localparam logic [12:0] OY     = 13'(OFFS_Y);
  localparam logic [7:0]  AF     = 8'(ATTACK_FRAMES);
  localparam logic [7:0]  CF     = 8'(COOLDOWN_FRAMES);

  state_t      state [2];
  logic [7:0]  count [2];
  logic        vsync_q;
  logic [1:0]  fire_q;
  logic [1:0]  launch_q;
  logic [1:0]  launch_d;
  logic        tick;
  logic [12:0] sum_x [2];
  logic [12:0] sum_y [2];
  logic [11:0] anchor_x [2];
  logic [11:0] anchor_y [2];

  assign tick = vsync_in & ~vsync_q;

`ifdef ATTACK_AUTOREPEAT_EN
  assign launch_d = fire;
`else
  assign launch_d = fire & ~fire_q;
`endif

  // 13-bit sums cannot wrap, so the clamp sees the true anchor position
  always_comb begin
    sum_x[0] = {1'b0, p0_x} + OX;
    sum_y[0] = {1'b0, p0_y} + OY;
    sum_x[1] = {1'b0, p1_x} + OX;
    sum_y[1] = {1'b0, p1_y} + OY;
    for (int i = 0; i < 2; i++) begin
      anchor_x[i] = (sum_x[i] > X_MAX) ? X_MAX[11:0] : sum_x[i][11:0];
      anchor_y[i] = (sum_y[i] > Y_MAX) ? Y_MAX[11:0] : sum_y[i][11:0];
    end
  end

  // Slot 0 is processed last so it wins direction on a simultaneous launch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsync_q   <= 1'b0;
      fire_q    <= 2'b00;
      launch_q  <= 2'b00;
      x_pos     <= {PARK, PARK};
      y_pos     <= {PARK, PARK};
      direction <= 1'b1;
      active    <= 2'b00;
      busy      <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        state[i] <= IDLE;
        count[i] <= 8'd0;
      end
    end else begin
      vsync_q  <= vsync_in;
      fire_q   <= fire;
      launch_q <= launch_d;
      for (int i = 1; i >= 0; i--) begin
        case (state[i])
          IDLE: begin
            if (launch_q[i]) begin
              state[i]            <= ATTACK;
              count[i]            <= AF;
              x_pos[i*12 +: 12]   <= anchor_x[i];
              y_pos[i*12 +: 12]   <= anchor_y[i];
              direction           <= dir_in[i];
              active[i]           <= 1'b1;
              busy[i]             <= 1'b1;
            end
          end
          ATTACK: begin
            if (tick) begin
              if (count[i] == 8'd1) begin
                x_pos[i*12 +: 12] <= PARK;
                y_pos[i*12 +: 12] <= PARK;
                active[i]         <= 1'b0;
                if (CF == 8'd0) begin
                  state[i] <= IDLE;
                  count[i] <= 8'd0;
                  busy[i]  <= 1'b0;
                end else begin
                  state[i] <= COOLDOWN;
                  count[i] <= CF;
                end
              end else begin
                count[i] <= count[i] - 8'd1;
              end
            end
          end
          COOLDOWN: begin
            if (tick) begin
              if (count[i] == 8'd1) begin
                state[i] <= IDLE;
                count[i] <= 8'd0;
                busy[i]  <= 1'b0;
              end else begin
                count[i] <= count[i] - 8'd1;
              end
            end
          end
          default: begin
            state[i] <= IDLE;
            count[i] <= 8'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/attack_ctl.md
Name: attack_ctl

Overview:
- Per-player attack sequencer; sits directly upstream of the attack-rectangle draw stage and produces its packed x_pos/y_pos/direction inputs.
- Turns two fire buttons into timed attack windows: launch, hold for N frames, cooldown, re-arm.
- Timing is in frames, counted on rising edges of vsync_in; rectangle anchors are latched from player positions at launch.

Parameters:
- ATTACK_FRAMES, 12, frames an attack rectangle stays visible (1..255)
- COOLDOWN_FRAMES, 20, frames after an attack before re-arm (0..255)
- OFFS_X, 40, x offset from player origin to rectangle anchor
- OFFS_Y, 10, y offset from player origin to rectangle anchor
- H_LIMIT, 800, exclusive max anchor x; larger values clamp to H_LIMIT-1
- V_LIMIT, 600, exclusive max anchor y; larger values clamp to V_LIMIT-1
- PARK, 12'hFFF, anchor value for an inactive slot; never matches an 11-bit hcount/vcount

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- vsync_in  in  1  frame sync from the timing chain
- fire  in  2  fire buttons, synchronous level, bit i = player i
- dir_in  in  2  player facing, bit i: 1 = horizontal, 0 = vertical
- p0_x, p0_y  in  12 each  player 0 origin
- p1_x, p1_y  in  12 each  player 1 origin
- x_pos  out  24  {slot1_x, slot0_x}
- y_pos  out  24  {slot1_y, slot0_y}
- direction  out  1  shared rectangle orientation
- active  out  2  bit i high while slot i is in ATTACK
- busy  out  2  bit i high in ATTACK or COOLDOWN

Behaviour:
- Reset (rst low): all outputs registered and cleared asynchronously.
  - x_pos and y_pos = {PARK, PARK}; direction = 1; active = 0; busy = 0.
  - Internal counters = 0; both FSMs go to IDLE; fire and vsync history registers = 0.
- Frame tick: vsync_q holds last-cycle vsync_in. tick = vsync_in & ~vsync_q, a one-cycle pulse.
- Fire edge: fire_q holds last-cycle fire. launch_i = fire[i] & ~fire_q[i].
- FSM per slot: IDLE, ATTACK, COOLDOWN.
  - IDLE -> ATTACK on launch_i.
    - Anchors latched: x = min(pi_x + OFFS_X, H_LIMIT-1), y = min(pi_y + OFFS_Y, V_LIMIT-1).
    - Sums use 13-bit width with no wrap.
    - Counter loaded with ATTACK_FRAMES.
  - ATTACK: counter decrements on tick. At tick with counter==1 the slot goes to COOLDOWN, its anchors go to PARK, and the counter loads COOLDOWN_FRAMES.
    - If COOLDOWN_FRAMES==0 the slot goes straight to IDLE.
  - COOLDOWN: decrements on tick; at tick with counter==1 -> IDLE.
  - launch_i in ATTACK or COOLDOWN is ignored and not queued. Holding fire through cooldown does not relaunch; the button must be released and pressed again.
- Latency: anchors, active and direction are updated on the clock edge after the fire edge is sampled, i.e. 2 clk after fire rises.
- Partial frames: a launch mid-frame counts the partial frame as frame 1. Visible duration is therefore ATTACK_FRAMES-1 to ATTACK_FRAMES frames.
- direction:
  - Loaded with dir_in[i] when slot i launches.
  - Both slots launch in the same cycle: dir_in[0] wins.
  - A later launch overwrites the value while the other slot is active (last launch wins).
  - Held while both slots are idle.
- Player positions are sampled only at launch; player movement during ATTACK does not move the rectangle.
- Simultaneous tick and launch on an IDLE slot: launch wins and the counter loads the full ATTACK_FRAMES, with no decrement that cycle.
- Reset asserted mid-attack: immediate park, no cooldown carried over.

Optional Feature:
- Macro ATTACK_AUTOREPEAT_EN.
- Defined: launch_i = fire[i] in IDLE (level, not edge). Holding fire relaunches on the cycle after COOLDOWN ends, re-sampling the current player position.
- Undefined: edge-triggered as above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset: rst low mid-run -> x_pos=y_pos=24'hFFFFFF, active=0, busy=0, direction=1 within the same cycle, asynchronously.
- Single attack: p0=(100,200), dir_in=2'b01, pulse fire[0] -> 2 clk later x_pos[11:0]=140, y_pos[11:0]=210, direction=1, active=2'b01.
  - With ATTACK_FRAMES=12: the slot parks on the 12th tick. busy[0] clears on the 20th tick after that.
- Clamp: p1=(790,595), fire[1] -> x_pos[23:12]=799, y_pos[23:12]=599.
- Simultaneous: both fire in one cycle, dir_in=2'b10 -> both slots active, direction=0.
  - A later launch of slot 1 alone with dir_in[1]=1 sets direction=1.
- Cooldown block: fire[0] held high through attack and cooldown -> no relaunch.
  - Release then press -> relaunch.
  - With ATTACK_AUTOREPEAT_EN: relaunch 1 clk after busy[0] falls.
- Tick/launch collision: fire[0] edge in the same cycle as a vsync rising edge -> counter=ATTACK_FRAMES and active for the full 12 ticks.
